spi_axi_sched: RTL and testbench

Sequencer/arbiter sharing one AXI4-Lite master port between two requesters: the SPI slave command decoder (single-cycle spi_write/spi_read pulses) and a local host port (valid/ready). Holds one pending SPI command, round-robins the bus, runs the AXI4-Lite handshakes, and returns read data to the SPI slave's spi_read_data input or to the host. Sits between the SPI slave front end and the SoC AXI interconnect, all in core_clk.

---
 rtl/spi_axi_sched_pkg.sv | 29 ++
 rtl/spi_axi_sched_rr2.sv | 29 ++
 rtl/spi_axi_sched.sv | 244 ++++++++++++++++++++++++
 tb/tb_spi_axi_sched.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_axi_sched_pkg.sv
// Shared types for spi_axi_sched: FSM states, AXI response codes, requester ids.
package spi_axi_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_RESP,
        ST_RD,
        ST_RD_RESP,
        ST_DONE,
        ST_DRAIN
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        REQ_SPI  = 1'b0,
        REQ_HOST = 1'b1
    } req_id_e;

    // Anything other than plain OKAY (EXOKAY included) is treated as a failure.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/spi_axi_sched_rr2.sv
// Two-way round-robin arbiter; last_grant starts at HOST so SPI wins the first contest.
module spi_axi_sched_rr2
    import spi_axi_sched_pkg::*;
(
    input  logic core_clk,
    input  logic core_reset_n,
    input  logic arb_en_i,
    input  logic req_spi_i,
    input  logic req_host_i,
    output logic gnt_spi_o,
    output logic gnt_host_o
);

    req_id_e last_grant_q;

    assign gnt_spi_o  = arb_en_i && req_spi_i && (!req_host_i || last_grant_q == REQ_HOST);
    assign gnt_host_o = arb_en_i && req_host_i && !gnt_spi_o;

    always_ff @(posedge core_clk or negedge core_reset_n) begin
        if (!core_reset_n) begin
            last_grant_q <= REQ_HOST;
        end else if (gnt_spi_o) begin
            last_grant_q <= REQ_SPI;
        end else if (gnt_host_o) begin
            last_grant_q <= REQ_HOST;
        end
    end

endmodule

// File: rtl/spi_axi_sched.sv
// Shares one AXI4-Lite master between a pulsed SPI command port and a valid/ready host port.
// Define SPI_AXI_SCHED_TIMEOUT_EN to enable the response timeout counter and DRAIN state.
module spi_axi_sched
    import spi_axi_sched_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 20,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic                  core_clk,
    input  logic                  core_reset_n,
    input  logic                  spi_write,
    input  logic                  spi_read,
    input  logic [ADDR_WIDTH-1:0] spi_write_address,
    input  logic [ADDR_WIDTH-1:0] spi_read_address,
    input  logic [31:0]           spi_write_data,
    output logic [31:0]           spi_read_data,
    output logic                  spi_busy,
    output logic                  spi_overflow,
    input  logic                  ovf_clr,
    input  logic                  host_req_valid,
    output logic                  host_req_ready,
    input  logic                  host_req_we,
    input  logic [ADDR_WIDTH-1:0] host_req_addr,
    input  logic [31:0]           host_req_wdata,
    output logic                  host_rsp_valid,
    output logic [31:0]           host_rsp_rdata,
    output logic                  host_rsp_err,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [31:0]           m_axi_awaddr,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    input  logic [1:0]            m_axi_bresp,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    output logic [31:0]           m_axi_araddr,
    output logic [2:0]            m_axi_arprot,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp
);

    state_e                state_q;
    req_id_e               owner_q;
    logic                  hold_valid_q, hold_we_q, spi_overflow_q;
    logic [ADDR_WIDTH-1:0] hold_addr_q;
    logic [31:0]           hold_wdata_q, spi_read_data_q;
    logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic [31:0]           axi_addr_q, axi_wdata_q;
    logic                  host_rsp_valid_q, host_rsp_err_q;
    logic [31:0]           host_rsp_rdata_q;

    logic gnt_spi, gnt_host;
    logic spi_pulse, spi_inflight, spi_accept;

    spi_axi_sched_rr2 u_rr2 (
        .core_clk     (core_clk),
        .core_reset_n (core_reset_n),
        .arb_en_i     (state_q == ST_IDLE),
        .req_spi_i    (hold_valid_q),
        .req_host_i   (host_req_valid),
        .gnt_spi_o    (gnt_spi),
        .gnt_host_o   (gnt_host)
    );

    assign spi_pulse    = spi_write || spi_read;
    assign spi_inflight = (owner_q == REQ_SPI) && (state_q != ST_IDLE);
    assign spi_accept   = spi_pulse && !hold_valid_q && !spi_inflight;

    // One-deep SPI holding register; a simultaneous write+read keeps the write and flags overflow.
    always_ff @(posedge core_clk or negedge core_reset_n) begin
        if (!core_reset_n) begin
            hold_valid_q   <= 1'b0;
            hold_we_q      <= 1'b0;
            hold_addr_q    <= '0;
            hold_wdata_q   <= '0;
            spi_overflow_q <= 1'b0;
        end else begin
            if (gnt_spi) begin
                hold_valid_q <= 1'b0;
            end
            if (spi_accept) begin
                hold_valid_q <= 1'b1;
                hold_we_q    <= spi_write;
                hold_addr_q  <= spi_write ? spi_write_address : spi_read_address;
                hold_wdata_q <= spi_write_data;
            end
            if ((spi_pulse && !spi_accept) || (spi_write && spi_read)) begin
                spi_overflow_q <= 1'b1;
            end else if (ovf_clr) begin
                spi_overflow_q <= 1'b0;
            end
        end
    end

    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [31:0]           sel_wdata;

    assign sel_we    = gnt_spi ? hold_we_q    : host_req_we;
    assign sel_addr  = gnt_spi ? hold_addr_q  : host_req_addr;
    assign sel_wdata = gnt_spi ? hold_wdata_q : host_req_wdata;

    logic        in_resp, resp_fire, timeout_fire, cmpl_fire, cmpl_err;
    logic [31:0] cmpl_data;

    assign in_resp   = (state_q == ST_WR_RESP) || (state_q == ST_RD_RESP);
    assign resp_fire = ((state_q == ST_WR_RESP) && m_axi_bvalid) ||
                       ((state_q == ST_RD_RESP) && m_axi_rvalid);

`ifdef SPI_AXI_SCHED_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;

    // Counts response-phase cycles; the TIMEOUT_CYCLES-th silent cycle expires.
    always_ff @(posedge core_clk or negedge core_reset_n) begin
        if (!core_reset_n) begin
            tmo_cnt_q <= '0;
        end else if (in_resp) begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end else begin
            tmo_cnt_q <= '0;
        end
    end

    assign timeout_fire = in_resp && !resp_fire && (tmo_cnt_q + 16'd1 == 16'(TIMEOUT_CYCLES));
`else
    logic [15:0] timeout_cycles_unused;
    assign timeout_cycles_unused = 16'(TIMEOUT_CYCLES);
    assign timeout_fire          = 1'b0;
`endif

    assign cmpl_fire = resp_fire || timeout_fire;
    assign cmpl_err  = timeout_fire ||
                       ((state_q == ST_WR_RESP) ? resp_is_err(m_axi_bresp) : resp_is_err(m_axi_rresp));
    assign cmpl_data = cmpl_err ? ERR_DATA : ((state_q == ST_RD_RESP) ? m_axi_rdata : 32'h0);

    always_ff @(posedge core_clk or negedge core_reset_n) begin
        if (!core_reset_n) begin
            state_q          <= ST_IDLE;
            owner_q          <= REQ_SPI;
            awvalid_q        <= 1'b0;
            wvalid_q         <= 1'b0;
            bready_q         <= 1'b0;
            arvalid_q        <= 1'b0;
            rready_q         <= 1'b0;
            axi_addr_q       <= '0;
            axi_wdata_q      <= '0;
            spi_read_data_q  <= '0;
            host_rsp_valid_q <= 1'b0;
            host_rsp_rdata_q <= '0;
            host_rsp_err_q   <= 1'b0;
        end else begin
            host_rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (gnt_spi || gnt_host) begin
                        owner_q     <= gnt_spi ? REQ_SPI : REQ_HOST;
                        axi_addr_q  <= 32'({sel_addr, 2'b00});
                        axi_wdata_q <= sel_wdata;
                        if (sel_we) begin
                            state_q   <= ST_WR;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else begin
                            state_q   <= ST_RD;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                ST_WR: begin
                    if (m_axi_awready) awvalid_q <= 1'b0;
                    if (m_axi_wready)  wvalid_q  <= 1'b0;
                    if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
                        state_q  <= ST_WR_RESP;
                        bready_q <= 1'b1;
                    end
                end
                ST_RD: begin
                    if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RD_RESP;
                    end
                end
                ST_WR_RESP, ST_RD_RESP: begin
                    if (resp_fire) begin
                        bready_q <= 1'b0;
                        rready_q <= 1'b0;
                        state_q  <= ST_DONE;
                    end else if (timeout_fire) begin
                        state_q  <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Late response is accepted and discarded.
                    if ((bready_q && m_axi_bvalid) || (rready_q && m_axi_rvalid)) begin
                        bready_q <= 1'b0;
                        rready_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (cmpl_fire) begin
                if (owner_q == REQ_HOST) begin
                    host_rsp_valid_q <= 1'b1;
                    host_rsp_rdata_q <= cmpl_data;
                    host_rsp_err_q   <= cmpl_err;
                end else if (state_q == ST_RD_RESP) begin
                    spi_read_data_q  <= cmpl_data;
                end
            end
        end
    end

    assign spi_read_data  = spi_read_data_q;
    assign spi_busy       = hold_valid_q || spi_inflight;
    assign spi_overflow   = spi_overflow_q;
    assign host_req_ready = gnt_host;
    assign host_rsp_valid = host_rsp_valid_q;
    assign host_rsp_rdata = host_rsp_rdata_q;
    assign host_rsp_err   = host_rsp_err_q;

    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awaddr  = axi_addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_wdata   = axi_wdata_q;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_bready  = bready_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = axi_addr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_spi_axi_sched.sv
// Directed bench for spi_axi_sched with a zero-wait AXI4-Lite slave model (BVALID can be withheld).
module tb_spi_axi_sched;

    logic        core_clk = 1'b0;
    logic        core_reset_n = 1'b0;
    logic        spi_write = 1'b0, spi_read = 1'b0;
    logic [19:0] spi_write_address = '0, spi_read_address = '0;
    logic [31:0] spi_write_data = '0;
    logic [31:0] spi_read_data;
    logic        spi_busy, spi_overflow;
    logic        ovf_clr = 1'b0;
    logic        host_req_valid = 1'b0, host_req_we = 1'b0;
    logic        host_req_ready;
    logic [19:0] host_req_addr = '0;
    logic [31:0] host_req_wdata = '0;
    logic        host_rsp_valid, host_rsp_err;
    logic [31:0] host_rsp_rdata;
    logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
    logic        m_axi_bvalid, m_axi_rvalid;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic [3:0]  m_axi_wstrb;
    logic [1:0]  m_axi_bresp, m_axi_rresp;

    int n_checks = 0;
    int n_fail = 0;

    // Slave model state
    logic        b_pending, r_pending;
    logic        b_block = 1'b0;
    logic [1:0]  slv_bresp = 2'b00, slv_rresp = 2'b00;
    logic [31:0] slv_rdata = '0;
    logic [31:0] w_last, ar_last;
    logic [31:0] aw_log[$];
    int          aw_count;

    always #5 core_clk = ~core_clk;

    spi_axi_sched #(
        .ADDR_WIDTH     (20),
        .TIMEOUT_CYCLES (8),
        .ERR_DATA       (32'hDEAD_BEEF)
    ) dut (
        .core_clk          (core_clk),
        .core_reset_n      (core_reset_n),
        .spi_write         (spi_write),
        .spi_read          (spi_read),
        .spi_write_address (spi_write_address),
        .spi_read_address  (spi_read_address),
        .spi_write_data    (spi_write_data),
        .spi_read_data     (spi_read_data),
        .spi_busy          (spi_busy),
        .spi_overflow      (spi_overflow),
        .ovf_clr           (ovf_clr),
        .host_req_valid    (host_req_valid),
        .host_req_ready    (host_req_ready),
        .host_req_we       (host_req_we),
        .host_req_addr     (host_req_addr),
        .host_req_wdata    (host_req_wdata),
        .host_rsp_valid    (host_rsp_valid),
        .host_rsp_rdata    (host_rsp_rdata),
        .host_rsp_err      (host_rsp_err),
        .m_axi_awvalid     (m_axi_awvalid),
        .m_axi_awready     (1'b1),
        .m_axi_awaddr      (m_axi_awaddr),
        .m_axi_awprot      (m_axi_awprot),
        .m_axi_wvalid      (m_axi_wvalid),
        .m_axi_wready      (1'b1),
        .m_axi_wdata       (m_axi_wdata),
        .m_axi_wstrb       (m_axi_wstrb),
        .m_axi_bvalid      (m_axi_bvalid),
        .m_axi_bready      (m_axi_bready),
        .m_axi_bresp       (m_axi_bresp),
        .m_axi_arvalid     (m_axi_arvalid),
        .m_axi_arready     (1'b1),
        .m_axi_araddr      (m_axi_araddr),
        .m_axi_arprot      (m_axi_arprot),
        .m_axi_rvalid      (m_axi_rvalid),
        .m_axi_rready      (m_axi_rready),
        .m_axi_rdata       (m_axi_rdata),
        .m_axi_rresp       (m_axi_rresp)
    );

    assign m_axi_bvalid = b_pending && !b_block;
    assign m_axi_bresp  = slv_bresp;
    assign m_axi_rvalid = r_pending;
    assign m_axi_rdata  = slv_rdata;
    assign m_axi_rresp  = slv_rresp;

    // Ready is tied high, so a response is pending from the cycle after the address handshake.
    always @(posedge core_clk or negedge core_reset_n) begin
        if (!core_reset_n) begin
            b_pending <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            if (m_axi_awvalid && m_axi_wvalid) begin
                b_pending <= 1'b1;
                w_last    <= m_axi_wdata;
                aw_count  <= aw_count + 1;
                aw_log.push_back(m_axi_awaddr);
            end else if (m_axi_bvalid && m_axi_bready) begin
                b_pending <= 1'b0;
            end
            if (m_axi_arvalid) begin
                r_pending <= 1'b1;
                ar_last   <= m_axi_araddr;
            end else if (m_axi_rvalid && m_axi_rready) begin
                r_pending <= 1'b0;
            end
        end
    end

    task automatic host_send(input logic we, input logic [19:0] addr, input logic [31:0] wdata);
        int n;
        host_req_valid = 1'b1;
        host_req_we    = we;
        host_req_addr  = addr;
        host_req_wdata = wdata;
        n = 0;
        #1;
        while (!host_req_ready && n < 100) begin
            @(negedge core_clk);
            #1;
            n++;
        end
        if (!host_req_ready) begin
            n_checks++; n_fail++;
            $display("FAIL host_accept: ready=%0b after %0d cycles, required 1", host_req_ready, n);
        end
        @(posedge core_clk);
        #1;
        host_req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name);
        int n;
        n = 0;
        @(negedge core_clk);
        while (!host_rsp_valid && n < 50) begin
            @(negedge core_clk);
            n++;
        end
        if (!host_rsp_valid) begin
            n_checks++; n_fail++;
            $display("FAIL %s_rsp_timeout: host_rsp_valid=0 after %0d cycles, required 1", name, n);
        end
    endtask

    task automatic test_reset();
        core_reset_n = 1'b0;
        repeat (2) @(negedge core_clk);
        n_checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 5'b0) begin
            n_fail++; $display("FAIL rst_axi_ctl: got %b required 00000",
                {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready});
        end
        n_checks++;
        if (spi_read_data !== 32'h0) begin n_fail++; $display("FAIL rst_spi_read_data: got %h required 0", spi_read_data); end
        n_checks++;
        if (spi_busy !== 1'b0) begin n_fail++; $display("FAIL rst_spi_busy: got %b required 0", spi_busy); end
        n_checks++;
        if (spi_overflow !== 1'b0) begin n_fail++; $display("FAIL rst_spi_overflow: got %b required 0", spi_overflow); end
        n_checks++;
        if (host_req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_host_req_ready: got %b required 0", host_req_ready); end
        n_checks++;
        if (host_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_host_rsp_valid: got %b required 0", host_rsp_valid); end
        n_checks++;
        if (host_rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_host_rsp_rdata: got %h required 0", host_rsp_rdata); end
        n_checks++;
        if (host_rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_host_rsp_err: got %b required 0", host_rsp_err); end
        core_reset_n = 1'b1;
        @(negedge core_clk);
        $display("reset: outputs checked");
    endtask

    task automatic test_spi_write();
        int start_cnt;
        start_cnt = aw_count;
        spi_write = 1'b1; spi_write_address = 20'h00010; spi_write_data = 32'h1234_5678;
        @(negedge core_clk);                        // N+1
        spi_write = 1'b0;
        n_checks++;
        if (spi_busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy_n1: got %b required 1", spi_busy); end
        n_checks++;
        if (m_axi_awvalid !== 1'b0) begin n_fail++; $display("FAIL wr_awvalid_n1: got %b required 0", m_axi_awvalid); end
        @(negedge core_clk);                        // N+2
        n_checks++;
        if ({m_axi_awvalid, m_axi_wvalid} !== 2'b11) begin
            n_fail++; $display("FAIL wr_valids_n2: got %b required 11", {m_axi_awvalid, m_axi_wvalid});
        end
        n_checks++;
        if (m_axi_awaddr !== 32'h40) begin n_fail++; $display("FAIL wr_awaddr: got %h required 00000040", m_axi_awaddr); end
        n_checks++;
        if (m_axi_wdata !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_wdata: got %h required 12345678", m_axi_wdata); end
        n_checks++;
        if (m_axi_wstrb !== 4'hF) begin n_fail++; $display("FAIL wr_wstrb: got %h required f", m_axi_wstrb); end
        @(negedge core_clk);                        // N+3
        n_checks++;
        if (m_axi_bready !== 1'b1) begin n_fail++; $display("FAIL wr_bready_n3: got %b required 1", m_axi_bready); end
        @(negedge core_clk);                        // N+4
        n_checks++;
        if (spi_busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy_n4: got %b required 1", spi_busy); end
        @(negedge core_clk);                        // N+5
        n_checks++;
        if (spi_busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_n5: got %b required 0", spi_busy); end
        n_checks++;
        if (aw_count !== start_cnt + 1) begin n_fail++; $display("FAIL wr_aw_count: got %0d required %0d", aw_count, start_cnt + 1); end
        $display("spi write: awaddr=%h wdata=%h", m_axi_awaddr, w_last);
    endtask

    task automatic test_spi_read();
        slv_rdata = 32'hCAFE_F00D; slv_rresp = 2'b00;
        spi_read = 1'b1; spi_read_address = 20'h00004;
        @(negedge core_clk);                        // N+1
        spi_read = 1'b0;
        @(negedge core_clk);                        // N+2
        n_checks++;
        if (m_axi_arvalid !== 1'b1) begin n_fail++; $display("FAIL rd_arvalid_n2: got %b required 1", m_axi_arvalid); end
        n_checks++;
        if (m_axi_araddr !== 32'h10) begin n_fail++; $display("FAIL rd_araddr: got %h required 00000010", m_axi_araddr); end
        @(negedge core_clk);                        // N+3: handshake cycle, old value still held
        n_checks++;
        if (spi_read_data !== 32'h0) begin n_fail++; $display("FAIL rd_data_n3: got %h required 00000000", spi_read_data); end
        @(negedge core_clk);                        // N+4
        n_checks++;
        if (spi_read_data !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rd_data_n4: got %h required cafef00d", spi_read_data); end
        @(negedge core_clk);                        // N+5
        n_checks++;
        if (spi_busy !== 1'b0) begin n_fail++; $display("FAIL rd_busy_n5: got %b required 0", spi_busy); end
        $display("spi read: araddr=%h data=%h", ar_last, spi_read_data);
    endtask

    task automatic test_overflow();
        int start_cnt;
        start_cnt = aw_count;
        slv_rdata = 32'h0BAD_C0DE;
        spi_read = 1'b1; spi_read_address = 20'h00008;
        @(negedge core_clk);                        // N+1
        spi_read = 1'b0;
        @(negedge core_clk);                        // N+2: read in flight
        spi_write = 1'b1; spi_write_address = 20'h00050; spi_write_data = 32'h7777_7777;
        @(negedge core_clk);                        // N+3
        spi_write = 1'b0;
        n_checks++;
        if (spi_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b required 1", spi_overflow); end
        repeat (3) @(negedge core_clk);             // N+6
        n_checks++;
        if (spi_busy !== 1'b0) begin n_fail++; $display("FAIL ovf_busy_idle: got %b required 0", spi_busy); end
        n_checks++;
        if (aw_count !== start_cnt) begin n_fail++; $display("FAIL ovf_dropped_write: aw_count %0d required %0d", aw_count, start_cnt); end
        n_checks++;
        if (spi_read_data !== 32'h0BAD_C0DE) begin n_fail++; $display("FAIL ovf_read_data: got %h required 0badc0de", spi_read_data); end
        n_checks++;
        if (spi_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b required 1", spi_overflow); end
        ovf_clr = 1'b1;
        @(negedge core_clk);
        ovf_clr = 1'b0;
        n_checks++;
        if (spi_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b required 0", spi_overflow); end
        // write and read pulses together: write proceeds, overflow flagged
        spi_write = 1'b1; spi_read = 1'b1;
        spi_write_address = 20'h00030; spi_read_address = 20'h00031; spi_write_data = 32'hA5A5_0001;
        @(negedge core_clk);
        spi_write = 1'b0; spi_read = 1'b0;
        n_checks++;
        if (spi_overflow !== 1'b1) begin n_fail++; $display("FAIL dual_ovf: got %b required 1", spi_overflow); end
        @(negedge core_clk);
        n_checks++;
        if ({m_axi_awvalid, m_axi_arvalid} !== 2'b10) begin
            n_fail++; $display("FAIL dual_write_wins: aw/ar valid %b required 10", {m_axi_awvalid, m_axi_arvalid});
        end
        n_checks++;
        if (m_axi_awaddr !== 32'hC0) begin n_fail++; $display("FAIL dual_awaddr: got %h required 000000c0", m_axi_awaddr); end
        repeat (3) @(negedge core_clk);
        ovf_clr = 1'b1;
        @(negedge core_clk);
        ovf_clr = 1'b0;
        $display("overflow: dropped pulse flagged, dual pulse wrote %h", w_last);
    endtask

    task automatic test_host_resp();
        slv_rresp = 2'b10; slv_rdata = 32'h1111_1111;
        host_send(1'b0, 20'h00100, 32'h0);
        wait_rsp("slverr");
        n_checks++;
        if (host_rsp_err !== 1'b1) begin n_fail++; $display("FAIL slverr_err: got %b required 1", host_rsp_err); end
        n_checks++;
        if (host_rsp_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL slverr_rdata: got %h required deadbeef", host_rsp_rdata); end
        n_checks++;
        if (ar_last !== 32'h400) begin n_fail++; $display("FAIL host_araddr: got %h required 00000400", ar_last); end
        @(negedge core_clk);
        n_checks++;
        if (host_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rsp_pulse_width: got %b required 0", host_rsp_valid); end
        $display("host read slverr: rdata=%h err=%b", host_rsp_rdata, host_rsp_err);

        slv_rresp = 2'b00; slv_rdata = 32'h55AA_1234;
        host_send(1'b0, 20'h00200, 32'h0);
        wait_rsp("okay");
        n_checks++;
        if ({host_rsp_err, host_rsp_rdata} !== {1'b0, 32'h55AA_1234}) begin
            n_fail++; $display("FAIL okay_rsp: got err=%b rdata=%h required err=0 rdata=55aa1234", host_rsp_err, host_rsp_rdata);
        end
        $display("host read okay: rdata=%h err=%b", host_rsp_rdata, host_rsp_err);

        slv_bresp = 2'b11;
        host_send(1'b1, 20'h00300, 32'h9999_0000);
        wait_rsp("decerr");
        slv_bresp = 2'b00;
        n_checks++;
        if ({host_rsp_err, host_rsp_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
            n_fail++; $display("FAIL decerr_rsp: got err=%b rdata=%h required err=1 rdata=deadbeef", host_rsp_err, host_rsp_rdata);
        end
        n_checks++;
        if (spi_read_data !== 32'h0BAD_C0DE) begin n_fail++; $display("FAIL host_no_spi_update: got %h required 0badc0de", spi_read_data); end
        $display("host write decerr: rdata=%h err=%b", host_rsp_rdata, host_rsp_err);
    endtask

    // The SPI request becomes visible one cycle after its pulse, so the host is raised
    // then to make both contend in the same IDLE cycle.
    task automatic test_arbitration();
        logic [31:0] exp_log[4];
        exp_log[0] = 32'h4; exp_log[1] = 32'h8; exp_log[2] = 32'hC; exp_log[3] = 32'h10;
        test_reset();
        aw_log.delete();
        fork
            begin
                spi_write = 1'b1; spi_write_address = 20'h1; spi_write_data = 32'h5;
                @(negedge core_clk);
                spi_write = 1'b0;
                repeat (6) @(negedge core_clk);
                spi_write = 1'b1; spi_write_address = 20'h3;
                @(negedge core_clk);
                spi_write = 1'b0;
            end
            begin
                @(negedge core_clk);
                host_send(1'b1, 20'h2, 32'h6);
                host_send(1'b1, 20'h4, 32'h8);
            end
        join
        repeat (6) @(negedge core_clk);
        n_checks++;
        if (aw_log.size() !== 4) begin
            n_fail++; $display("FAIL arb_count: got %0d writes required 4", aw_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (aw_log[i] !== exp_log[i]) begin
                    n_fail++; $display("FAIL arb_order_%0d: got %h required %h", i, aw_log[i], exp_log[i]);
                end
            end
        end
        $display("arbitration: %0d grants logged", aw_log.size());
    endtask

`ifdef SPI_AXI_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        b_block = 1'b1;
        host_send(1'b1, 20'h00040, 32'h1);        // grant cycle G
        repeat (9) @(negedge core_clk);             // G+9: last waiting cycle
        n_checks++;
        if ({host_rsp_valid, m_axi_bready} !== 2'b01) begin
            n_fail++; $display("FAIL tmo_early: valid/bready %b required 01", {host_rsp_valid, m_axi_bready});
        end
        @(negedge core_clk);                        // G+10
        n_checks++;
        if ({host_rsp_valid, host_rsp_err, host_rsp_rdata} !== {2'b11, 32'hDEAD_BEEF}) begin
            n_fail++; $display("FAIL tmo_rsp: valid=%b err=%b rdata=%h required 1 1 deadbeef",
                host_rsp_valid, host_rsp_err, host_rsp_rdata);
        end
        @(negedge core_clk);                        // G+11: draining, release the late BVALID
        n_checks++;
        if (m_axi_bready !== 1'b1) begin n_fail++; $display("FAIL tmo_drain_bready: got %b required 1", m_axi_bready); end
        b_block = 1'b0;
        @(negedge core_clk);                        // G+12
        n_checks++;
        if ({m_axi_bready, host_rsp_valid} !== 2'b00) begin
            n_fail++; $display("FAIL tmo_drained: bready/valid %b required 00", {m_axi_bready, host_rsp_valid});
        end
        slv_rresp = 2'b00; slv_rdata = 32'h0123_4567;
        host_send(1'b0, 20'h00041, 32'h0);
        wait_rsp("tmo_recover");
        n_checks++;
        if ({host_rsp_err, host_rsp_rdata} !== {1'b0, 32'h0123_4567}) begin
            n_fail++; $display("FAIL tmo_recover: err=%b rdata=%h required 0 01234567", host_rsp_err, host_rsp_rdata);
        end
        $display("timeout: write drained, follow-up read rdata=%h", host_rsp_rdata);
    endtask
`endif

    initial begin
        aw_count = 0;
        test_reset();
        test_spi_write();
        test_spi_read();
        test_overflow();
        test_host_resp();
        test_arbitration();
`ifdef SPI_AXI_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
